vec_mul_sequencer: RTL and testbench

- Controller that sequences one vector-multiply job through the 8x8 datapath.
- Reads one weight tile from the weight SRAM and pulses the reload into the PE array.
- Streams N input vectors from the unified buffer, one per cycle.
- Writes the N results into the results SRAM after the fixed pipeline latency, then pulses done.
- Sits between the top-level start/config pins and the SRAM/PE-array control pins, replacing the free-running state counter.

---
 rtl/vec_mul_sequencer.sv | 138 +++++++++++++
 tb/tb_vec_mul_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vec_mul_sequencer.sv
// Job sequencer for one vector-multiply pass through the 8x8 datapath: optional weight
// tile load, N-vector stream from the unified buffer, results written after the array latency.
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE      = 10,
  parameter int ADDRESSSIZE_fifo = 2,
  parameter int PIPE_LATENCY     = 9,
  parameter int CNT_BW           = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        skip_wload,
  input  logic [ADDRESSSIZE_fifo-1:0] weight_sel,
  input  logic [ADDRESSSIZE-1:0]      src_base,
  input  logic [ADDRESSSIZE-1:0]      dst_base,
  input  logic [CNT_BW-1:0]           num_vecs,
  output logic [ADDRESSSIZE_fifo-1:0] wfifo_address,
  output logic                        weight_reload,
  output logic [ADDRESSSIZE-1:0]      ub_address,
  output logic                        ub_issue,
  output logic                        res_write_enable,
  output logic [ADDRESSSIZE-1:0]      res_address,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {IDLE, WL_RD, WL_LATCH, STREAM, DRAIN, FIN} state_t;

  localparam logic [ADDRESSSIZE-1:0] AddrOne = ADDRESSSIZE'(1);
  localparam logic [CNT_BW-1:0]      CntOne  = CNT_BW'(1);

  state_t                      state_q, state_d;
  logic [ADDRESSSIZE_fifo-1:0] wfifoAddr_q, wfifoAddr_d;
  logic [ADDRESSSIZE-1:0]      ubAddr_q, ubAddr_d;
  logic [ADDRESSSIZE-1:0]      resAddr_q, resAddr_d;
  logic [ADDRESSSIZE-1:0]      srcBase_q, srcBase_d;
  logic [CNT_BW-1:0]           numVecs_q, numVecs_d;
  logic [CNT_BW-1:0]           issueCnt_q, issueCnt_d;
  logic [PIPE_LATENCY-1:0]     pipe_q, pipe_d;
  logic                        ubIssue;

  always_comb begin
    state_d     = state_q;
    wfifoAddr_d = wfifoAddr_q;
    ubAddr_d    = ubAddr_q;
    resAddr_d   = resAddr_q;
    srcBase_d   = srcBase_q;
    numVecs_d   = numVecs_q;
    issueCnt_d  = issueCnt_q;
    ubIssue     = (state_q == STREAM);

    // Bit j of the shift register marks a vector issued j+1 cycles ago; the top tap is the write.
    pipe_d[0] = ubIssue;
    for (int j = 1; j < PIPE_LATENCY; j++) begin
      pipe_d[j] = pipe_q[j-1];
    end
    if (pipe_q[PIPE_LATENCY-1]) begin
      resAddr_d = resAddr_q + AddrOne;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          numVecs_d  = num_vecs;
          srcBase_d  = src_base;
          resAddr_d  = dst_base;
          issueCnt_d = '0;
          if (!skip_wload) begin
            wfifoAddr_d = weight_sel;
            state_d     = WL_RD;
          end else if (num_vecs != '0) begin
            ubAddr_d = src_base;
            state_d  = STREAM;
          end else begin
            state_d = FIN;
          end
        end
      end
      WL_RD: state_d = WL_LATCH;
      WL_LATCH: begin
        if (numVecs_q != '0) begin
          ubAddr_d = srcBase_q;
          state_d  = STREAM;
        end else begin
          state_d = FIN;
        end
      end
      STREAM: begin
        issueCnt_d = issueCnt_q + CntOne;
        if (issueCnt_q == numVecs_q - CntOne) begin
          state_d = DRAIN;
        end else begin
          ubAddr_d = ubAddr_q + AddrOne;
        end
      end
      // Leave once nothing remains in flight after this edge, i.e. the final write is this cycle.
      DRAIN: begin
        if (pipe_d == '0) begin
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wfifoAddr_q <= '0;
      ubAddr_q    <= '0;
      resAddr_q   <= '0;
      srcBase_q   <= '0;
      numVecs_q   <= '0;
      issueCnt_q  <= '0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      wfifoAddr_q <= wfifoAddr_d;
      ubAddr_q    <= ubAddr_d;
      resAddr_q   <= resAddr_d;
      srcBase_q   <= srcBase_d;
      numVecs_q   <= numVecs_d;
      issueCnt_q  <= issueCnt_d;
      pipe_q      <= pipe_d;
    end
  end

  assign wfifo_address    = wfifoAddr_q;
  assign weight_reload    = (state_q == WL_LATCH);
  assign ub_address       = ubAddr_q;
  assign ub_issue         = ubIssue;
  assign res_write_enable = pipe_q[PIPE_LATENCY-1];
  assign res_address      = resAddr_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FIN);

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Directed bench for vec_mul_sequencer: each job is checked cycle by cycle against
// a timeline derived from its configuration (weight phase, stream, pipeline, done).
module tb_vec_mul_sequencer;
  localparam int L = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        skip_wload;
  logic [1:0]  weight_sel;
  logic [9:0]  src_base;
  logic [9:0]  dst_base;
  logic [10:0] num_vecs;
  logic [1:0]  wfifo_address;
  logic        weight_reload;
  logic [9:0]  ub_address;
  logic        ub_issue;
  logic        res_write_enable;
  logic [9:0]  res_address;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  vec_mul_sequencer #(
    .ADDRESSSIZE(10), .ADDRESSSIZE_fifo(2), .PIPE_LATENCY(L), .CNT_BW(11)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .skip_wload(skip_wload),
    .weight_sel(weight_sel), .src_base(src_base), .dst_base(dst_base),
    .num_vecs(num_vecs), .wfifo_address(wfifo_address),
    .weight_reload(weight_reload), .ub_address(ub_address), .ub_issue(ub_issue),
    .res_write_enable(res_write_enable), .res_address(res_address),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic skip, input logic [1:0] wsel, input logic [9:0] src,
                               input logic [9:0] dst, input logic [10:0] n);
    skip_wload = skip;
    weight_sel = wsel;
    src_base   = src;
    dst_base   = dst;
    num_vecs   = n;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wfifo"}, 0, wfifo_address, 0);
    checkOutput({tag, "_reload"}, 0, weight_reload, 0);
    checkOutput({tag, "_ub_addr"}, 0, ub_address, 0);
    checkOutput({tag, "_ub_issue"}, 0, ub_issue, 0);
    checkOutput({tag, "_wen"}, 0, res_write_enable, 0);
    checkOutput({tag, "_res_addr"}, 0, res_address, 0);
    checkOutput({tag, "_busy"}, 0, busy, 0);
    checkOutput({tag, "_done"}, 0, done, 0);
  endtask

  // Called #1 after an edge; start is sampled at the next edge (cycle 0), then cycles 1.. observed.
  task automatic runJob(input logic skip, input logic [1:0] wsel, input logic [9:0] src,
                        input logic [9:0] dst, input logic [10:0] n, input int startAt,
                        input bit toggle);
    int wl, nInt, doneCyc, issues, writes;
    logic [9:0] expUb, expRes;
    wl      = skip ? 0 : 2;
    nInt    = int'(n);
    doneCyc = (nInt == 0) ? wl + 1 : wl + nInt + L + 1;
    issues  = 0;
    writes  = 0;
    applyStimulus(skip, wsel, src, dst, n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= doneCyc; c++) begin
      start = (c == startAt);
      if (toggle) begin
        applyStimulus(1'($urandom), 2'($urandom), 10'($urandom), 10'($urandom), 11'($urandom));
      end
      checkOutput("busy", c, busy, 1);
      checkOutput("done", c, done, c == doneCyc);
      checkOutput("weight_reload", c, weight_reload, !skip && c == 2);
      if (!skip) checkOutput("wfifo_address", c, wfifo_address, wsel);
      checkOutput("ub_issue", c, ub_issue, c >= wl + 1 && c <= wl + nInt);
      if (c >= wl + 1 && c <= wl + nInt) begin
        expUb = src + 10'(c - wl - 1);
        checkOutput("ub_address", c, ub_address, expUb);
      end
      checkOutput("res_write_enable", c, res_write_enable,
                  c >= wl + 1 + L && c <= wl + nInt + L);
      if (c >= wl + 1 + L && c <= wl + nInt + L) begin
        expRes = dst + 10'(c - wl - 1 - L);
        checkOutput("res_address", c, res_address, expRes);
      end
      if (ub_issue) issues++;
      if (res_write_enable) writes++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("busy_after_done", doneCyc + 1, busy, 0);
    checkOutput("done_after_done", doneCyc + 1, done, 0);
    checkOutput("issue_count", doneCyc, issues, nInt);
    checkOutput("write_count", doneCyc, writes, nInt);
  endtask

  initial begin
    int lateWrites, lateDone;
    rst   = 1'b1;
    start = 1'b0;
    applyStimulus(1'b0, 2'd0, 10'h000, 10'h000, 11'd0);
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    runJob(1'b0, 2'd2, 10'h010, 10'h100, 11'd8, 0, 1'b0);
    runJob(1'b1, 2'd0, 10'h3FE, 10'h3FF, 11'd3, 0, 1'b0);
    runJob(1'b0, 2'd1, 10'h000, 10'h000, 11'd0, 0, 1'b0);
    runJob(1'b1, 2'd3, 10'h0AA, 10'h055, 11'd0, 0, 1'b0);
    runJob(1'b0, 2'd1, 10'h200, 10'h050, 11'd5, 4, 1'b0);

    applyStimulus(1'b1, 2'd0, 10'h020, 10'h040, 11'd16);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_ub_addr", 4, ub_address, 10'h023);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkAllZero("midjob_reset");
    lateWrites = 0;
    lateDone   = 0;
    repeat (30) begin
      if (res_write_enable) lateWrites++;
      if (done) lateDone++;
      @(posedge clk); #1;
    end
    checkOutput("writes_after_reset", 0, lateWrites, 0);
    checkOutput("done_after_reset", 0, lateDone, 0);

    runJob(1'b0, 2'd3, 10'h3F0, 10'h1F8, 11'd6, 0, 1'b1);
    runJob(1'b1, 2'd0, 10'h100, 10'h300, 11'd2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
